// File: rtl/sort_unloader.sv
// Read-out end of the single_sort priority chain: snapshots the sorted chain on start,
// clears it, then streams the leading non-empty client/value pairs over valid/ready.
module sort_unloader #(
    parameter int unsigned CLIENTS_N        = 4,
    parameter int unsigned CLIENTS_BWIDTH_P = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [CLIENTS_N*8-1:0]                chain_val,
    input  logic [CLIENTS_N*CLIENTS_BWIDTH_P-1:0] chain_client,
    output logic                                  chain_clr,
    output logic                                  busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [CLIENTS_BWIDTH_P-1:0]           out_client,
    output logic [7:0]                            out_val,
    output logic                                  out_last,
    output logic                                  done,
    output logic                                  empty,
    output logic                                  order_err
);

    localparam int unsigned CntW = $clog2(CLIENTS_N + 1);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e                                state_q, state_d;
    logic [CLIENTS_N*8-1:0]                snap_val_q;
    logic [CLIENTS_N*CLIENTS_BWIDTH_P-1:0] snap_client_q;
    logic [CntW-1:0]                       cnt_q, idx_q, lead_cnt;
    logic                                  order_err_q, chain_clr_q, unsorted, run;
    logic                                  accept, last;

    assign accept = (state_q == StIdle) && start;
    assign last   = (idx_q == cnt_q - CntW'(1));

    // Leading run of non-empty stages; anything after the first empty stage is dropped.
    always_comb begin
        lead_cnt = '0;
        run      = 1'b1;
        unsorted = 1'b0;
        for (int i = 0; i < int'(CLIENTS_N); i++) begin
            if (chain_val[8*i +: 8] == 8'd0) run = 1'b0;
            if (run) lead_cnt = lead_cnt + CntW'(1);
        end
        for (int i = 0; i < int'(CLIENTS_N) - 1; i++) begin
            if (chain_val[8*(i+1) +: 8] > chain_val[8*i +: 8]) unsorted = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (lead_cnt != '0) ? StSend : StDone;
            StSend:  if (out_ready && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_val_q    <= '0;
            snap_client_q <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            order_err_q   <= 1'b0;
            chain_clr_q   <= 1'b0;
        end else begin
            chain_clr_q <= accept;
            if (accept) begin
                snap_val_q    <= chain_val;
                snap_client_q <= chain_client;
                cnt_q         <= lead_cnt;
                order_err_q   <= unsorted;
                idx_q         <= '0;
            end else if (state_q == StSend && out_ready && !last) begin
                idx_q <= idx_q + CntW'(1);
            end
        end
    end

    always_comb begin
        out_valid  = (state_q == StSend);
        out_last   = out_valid && last;
        out_val    = out_valid ? snap_val_q[8*int'(idx_q) +: 8] : 8'd0;
        out_client = out_valid ? snap_client_q[CLIENTS_BWIDTH_P*int'(idx_q) +: CLIENTS_BWIDTH_P]
                               : '0;
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        empty      = done && (cnt_q == '0);
        chain_clr  = chain_clr_q;
        order_err  = order_err_q;
    end

endmodule

// File: tb/tb_sort_unloader.sv
// Directed bench for sort_unloader with hand-computed expectations (CLIENTS_N=4).
module tb_sort_unloader;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [31:0] chain_val;
    logic [7:0]  chain_client;
    logic        chain_clr, busy, out_valid, out_last, done, empty, order_err;
    logic [1:0]  out_client;
    logic [7:0]  out_val;

    int n_checks = 0;
    int n_fail   = 0;

    sort_unloader #(.CLIENTS_N(4), .CLIENTS_BWIDTH_P(2)) dut (
        .clk(clk), .rst(rst), .start(start), .chain_val(chain_val),
        .chain_client(chain_client), .chain_clr(chain_clr), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_client(out_client),
        .out_val(out_val), .out_last(out_last), .done(done), .empty(empty),
        .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input string tag, input int cli, input int val, input bit lst);
        check_eq({tag, " valid"}, out_valid, 1);
        check_eq({tag, " client"}, out_client, cli);
        check_eq({tag, " val"}, out_val, val);
        check_eq({tag, " last"}, out_last, lst);
    endtask

    task automatic expect_idle_zero(input string tag);
        check_eq({tag, " outs"},
                 {chain_clr, busy, out_valid, out_client, out_val, out_last, done, empty,
                  order_err}, 0);
    endtask

    task automatic do_start(input logic [31:0] v, input logic [7:0] c);
        chain_val    = v;
        chain_client = c;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        chain_val    = 32'hFFFF_FFFF; // later chain changes must not matter
        chain_client = 8'h00;
    endtask

    int exp_cli[4] = '{3, 1, 0, 2};
    int exp_val[4] = '{200, 150, 90, 10};

    initial begin
        rst = 1'b0; start = 1'b0; out_ready = 1'b1;
        chain_val = '0; chain_client = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        expect_idle_zero("reset");

        // Full sorted chain, ready always high
        do_start({8'd10, 8'd90, 8'd150, 8'd200}, {2'd2, 2'd0, 2'd1, 2'd3});
        for (int k = 0; k < 4; k++) begin
            expect_entry("t1 entry", exp_cli[k], exp_val[k], k == 3);
            check_eq("t1 clr", chain_clr, k == 0);
            check_eq("t1 busy", busy, 1);
            tick();
        end
        check_eq("t1 done", done, 1);
        check_eq("t1 empty", empty, 0);
        check_eq("t1 order", order_err, 0);
        check_eq("t1 valid_done", out_valid, 0);
        tick();
        check_eq("t1 idle busy", busy, 0);
        check_eq("t1 idle done", done, 0);

        // Two entries with stalls: ready 1,0,0,1
        do_start({8'd0, 8'd0, 8'd20, 8'd50}, {2'd3, 2'd0, 2'd2, 2'd1});
        out_ready = 1'b1;
        expect_entry("t2 e0", 1, 50, 0);
        tick();
        out_ready = 1'b0;
        expect_entry("t2 e1 stall_a", 2, 20, 1);
        tick();
        expect_entry("t2 e1 stall_b", 2, 20, 1);
        tick();
        out_ready = 1'b1;
        expect_entry("t2 e1 accept", 2, 20, 1);
        tick();
        check_eq("t2 done", done, 1);
        check_eq("t2 empty", empty, 0);
        tick();
        check_eq("t2 idle", busy, 0);

        // Empty snapshot
        do_start(32'd0, 8'hE4);
        check_eq("t3 clr", chain_clr, 1);
        check_eq("t3 done", done, 1);
        check_eq("t3 empty", empty, 1);
        check_eq("t3 valid", out_valid, 0);
        tick();
        check_eq("t3 idle busy", busy, 0);
        check_eq("t3 idle clr", chain_clr, 0);
        check_eq("t3 idle valid", out_valid, 0);

        // Unsorted snapshot {30,80,0,5}
        do_start({8'd5, 8'd0, 8'd80, 8'd30}, {2'd3, 2'd2, 2'd1, 2'd0});
        check_eq("t4 order", order_err, 1);
        expect_entry("t4 e0", 0, 30, 0);
        tick();
        expect_entry("t4 e1", 1, 80, 1);
        tick();
        check_eq("t4 done", done, 1);
        check_eq("t4 order_done", order_err, 1);
        tick();
        check_eq("t4 idle busy", busy, 0);
        check_eq("t4 order_idle", order_err, 1);

        // Sorted start clears order_err; stray starts ignored
        do_start({8'd10, 8'd90, 8'd150, 8'd200}, {2'd2, 2'd0, 2'd1, 2'd3});
        check_eq("t5 order_clr", order_err, 0);
        for (int k = 0; k < 4; k++) begin
            expect_entry("t5 entry", exp_cli[k], exp_val[k], k == 3);
            check_eq("t5 clr", chain_clr, k == 0);
            start     = (k == 1);
            chain_val = 32'd0;
            tick();
            start = 1'b0;
        end
        check_eq("t5 done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t5 ignored busy", busy, 0);
        check_eq("t5 ignored clr", chain_clr, 0);
        do_start({8'd0, 8'd0, 8'd0, 8'd7}, {2'd0, 2'd0, 2'd0, 2'd2});
        check_eq("t5 restart clr", chain_clr, 1);
        expect_entry("t5 restart", 2, 7, 1);
        tick();
        check_eq("t5 restart done", done, 1);
        tick();

        // Reset while stalled
        out_ready = 1'b0;
        do_start({8'd5, 8'd0, 8'd80, 8'd30}, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        expect_entry("t6 stalled", 0, 30, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        expect_idle_zero("t6 after reset");
        tick();
        check_eq("t6 no done", done, 0);
        do_start({8'd0, 8'd0, 8'd20, 8'd50}, {2'd3, 2'd0, 2'd2, 2'd1});
        expect_entry("t6 e0", 1, 50, 0);
        tick();
        expect_entry("t6 e1", 2, 20, 1);
        tick();
        check_eq("t6 done", done, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_unloader.md
# sort_unloader

Read-out end of the cascaded `single_sort` priority chain. On a `start` pulse it snapshots the whole sorted chain (highest value at index 0) and clears the chain for the next sorting round. It then emits the non-empty client/value pairs one per handshake over a valid/ready stream, in descending-value order. It sits between the sort chain and the grant/arbitration logic that consumes the ranked client list.

## Interface

- `CLIENTS_N`, 4, number of chain stages read out; legal range 2..16
- `CLIENTS_BWIDTH_P`, 2, client ID width

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  single-cycle pulse: chain has settled, unload it; honoured only in IDLE
- `chain_val`  in  CLIENTS_N*8  stage values; stage i at bits [8i+7:8i], stage 0 = highest
- `chain_client`  in  CLIENTS_N*CLIENTS_BWIDTH_P  stage client IDs, same packing
- `chain_clr`  out  1  one-cycle clear pulse to every chain stage's `clr`
- `busy`  out  1  high in every state except IDLE
- `out_valid`  out  1  output entry valid
- `out_ready`  in  1  consumer accepts entry
- `out_client`  out  CLIENTS_BWIDTH_P  client ID of current entry
- `out_val`  out  8  priority value of current entry
- `out_last`  out  1  current entry is the final non-empty one
- `done`  out  1  one-cycle pulse, unload finished
- `empty`  out  1  valid with `done`: snapshot held no non-empty entry
- `order_err`  out  1  sticky: snapshot was not non-increasing; cleared by next accepted `start` or reset

## Operation

- Entry i is empty when `chain_val` slice i == 0.
- States: IDLE, SEND, DONE.
- IDLE with `start`=1:
  - Register all CLIENTS_N value/client pairs into a snapshot.
  - Set `cnt` = number of leading non-empty entries, counting from index 0 up to the first empty entry. Width $clog2(CLIENTS_N+1).
  - Set `order_err` = 1 if any val[i+1] > val[i]; otherwise clear it.
  - Reset read index `idx` to 0.
  - Next state: SEND if `cnt` != 0, else DONE.
- The chain is cleared one cycle after capture, whether or not any entry is non-empty. `chain_clr` is a registered output, high for exactly the cycle after `start` was accepted.
- SEND:
  - `out_valid`=1.
  - `out_client`/`out_val` = snapshot[`idx`].
  - `out_last` = (`idx` == `cnt`-1).
  - On `out_valid`&&`out_ready`: if `out_last`, go to DONE; else `idx`++.
  - While `out_ready`=0, outputs hold stable.
- DONE: `done`=1 for one cycle; `empty` = (`cnt`==0); then go to IDLE.
- Entries after the first empty entry are never emitted, even if non-zero; such a snapshot also sets `order_err`.
- `start` outside IDLE is ignored. No queuing and no effect on `chain_clr`.
- Chain inputs are sampled only on the accepted-`start` edge; later changes have no effect on the unload.

## Timing

- Reset (`rst`=0 at a clock edge) forces state IDLE, clears the snapshot, and zeroes `idx` and `cnt`.
- After reset every output is 0: `chain_clr`, `busy`, `out_valid`, `out_client`, `out_val`, `out_last`, `done`, `empty`, `order_err`.
- Reset wins over `start` and over any handshake in the same cycle.
- Reset mid-SEND drops `out_valid` on the next cycle with no `done` pulse.
- `start` accepted at edge of cycle T:
  - `busy`, `chain_clr` and `out_valid` all high in T+1, with entry 0 presented.
- Handshakes are zero-bubble: with `out_ready` held high, one entry is accepted per cycle.
  - `cnt`=N completes its last handshake in T+N.
  - `done`=1 in T+N+1.
  - IDLE, `busy`=0, in T+N+2.
  - Earliest new `start` accepted in T+N+2.
- Empty snapshot: `done`=`empty`=1 in T+1, IDLE in T+2, `out_valid` never asserted.
- `out_valid` never falls without a handshake, except on reset.
- `out_valid`, `out_client`, `out_val` and `out_last` are combinational from state and registers only; there is no combinational path from `out_ready` or `start` to any output.

## Test plan

- CLIENTS_N=4, chain vals {200,150,90,10}, clients {3,1,0,2}, `out_ready`=1:
  - Expect entries (3,200),(1,150),(0,90),(2,10) in cycles T+1..T+4.
  - `out_last` only at (2,10).
  - `chain_clr` only at T+1.
  - `done` at T+5, `empty`=0, `order_err`=0.
- Vals {50,20,0,0}, `out_ready` toggling 1,0,0,1:
  - Exactly two entries, each held stable through the stalls.
  - `out_last` on the second entry.
  - `done` the cycle after the second handshake.
- All vals 0:
  - `chain_clr` and `done`=`empty`=1 both at T+1.
  - `out_valid` stays 0.
  - Back in IDLE at T+2.
- Vals {30,80,0,5}:
  - `order_err`=1 and stays high after `done`.
  - `cnt`=2 emits (30),(80) only.
  - The next `start` with sorted data clears `order_err`.
- `start` pulsed again during SEND and on the `done` cycle: ignored, no extra `chain_clr`. A `start` at T+N+2 is accepted.
- `rst`=0 asserted while an entry is stalled (`out_ready`=0):
  - Next cycle all outputs are 0 and the state is IDLE; no `done` pulse.
  - A subsequent `start` unloads normally.
